montgomery_reduce_pipe: RTL and testbench



---
 rtl/montgomery_reduce_pipe_pkg.sv | 30 +++
 rtl/montgomery_reduce_pipe_lane.sv | 129 ++++++++++++
 rtl/montgomery_reduce_pipe.sv | 92 +++++++++
 tb/tb_montgomery_reduce_pipe.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/montgomery_reduce_pipe_pkg.sv
// Shared constants, stage-enable bundle and width helper for the Montgomery
// reduction pipeline (range checking is enabled with MONT_RANGE_CHK_EN).
package mont_pkg;

  // Kyber: N = 3329, R = 12, N_PRIME = -N^-1 mod 2^12
  localparam int unsigned     KYBER_NW      = 12;
  localparam longint unsigned KYBER_N       = 64'd3329;
  localparam int unsigned     KYBER_R       = 12;
  localparam longint unsigned KYBER_N_PRIME = 64'd3327;

  // Dilithium: N = 2^23 - 2^13 + 1, two common Montgomery exponents
  localparam int unsigned     DIL_NW          = 23;
  localparam longint unsigned DIL_N           = 64'd8380417;
  localparam int unsigned     DIL_R23         = 23;
  localparam longint unsigned DIL_N_PRIME_R23 = 64'd8380415;
  localparam int unsigned     DIL_R32         = 32;
  localparam longint unsigned DIL_N_PRIME_R32 = 64'd4236238847;

  typedef struct packed {
    logic s1;
    logic s2;
    logic s3;
    logic s4;
  } stage_en_t;

  function automatic int unsigned xw(input int unsigned nw, input int unsigned r);
    return nw + r;
  endfunction

endpackage

// File: rtl/montgomery_reduce_pipe_lane.sv
// One lane of the four-stage Montgomery datapath, y = X * 2^-R mod N.
// Stage loads come from the parent's handshake; MONT_RANGE_CHK_EN adds err.
module mont_lane
  import mont_pkg::*;
#(
  parameter int unsigned     NW      = KYBER_NW,
  parameter longint unsigned N       = KYBER_N,
  parameter int unsigned     R       = KYBER_R,
  parameter longint unsigned N_PRIME = KYBER_N_PRIME,
  parameter int unsigned     XW      = NW + R
) (
  input  logic          clk,
  input  logic          rst,
  input  stage_en_t     en,
  input  logic [XW-1:0] x,
  output logic [NW-1:0] y
`ifdef MONT_RANGE_CHK_EN
  ,
  output logic          err
`endif
);

  localparam logic [NW-1:0] N_V  = NW'(N);
  localparam logic [R-1:0]  NP_V = R'(N_PRIME);

  logic [XW-1:0] x1_q, x1_d;
  logic [R-1:0]  m_q, m_d;
  logic [XW-1:0] x2_q, x2_d;
  logic [XW-1:0] t_q, t_d;
  logic [XW:0]   u_q, u_d;
  logic [NW-1:0] y_q, y_d;
  logic [NW:0]   s;
  logic [NW-1:0] s_sub;

`ifdef MONT_RANGE_CHK_EN
  localparam logic [XW-1:0] X_LIMIT = {N_V, {R{1'b0}}};
  logic e1_q, e1_d;
  logic e2_q, e2_d;
  logic e3_q, e3_d;
  logic e4_q, e4_d;
`endif

  always_comb begin
    x1_d = x1_q;
    m_d  = m_q;
    x2_d = x2_q;
    t_d  = t_q;
    u_d  = u_q;
    y_d  = y_q;

    // only the low R bits of X matter for m mod 2^R
    if (en.s1) begin
      x1_d = x;
      m_d  = x[R-1:0] * NP_V;
    end

    if (en.s2) begin
      x2_d = x1_q;
      t_d  = XW'(m_q) * XW'(N_V);
    end

    if (en.s3) begin
      u_d = {1'b0, x2_q} + {1'b0, t_q};
    end

    // low R bits of u are zero by construction; s < 2N for in-range X
    s     = (NW + 1)'(u_q >> R);
    s_sub = NW'(s - {1'b0, N_V});

    if (en.s4) begin
      y_d = (s >= {1'b0, N_V}) ? s_sub : s[NW-1:0];
`ifdef MONT_RANGE_CHK_EN
      if (e3_q) begin
        y_d = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x1_q <= '0;
      m_q  <= '0;
      x2_q <= '0;
      t_q  <= '0;
      u_q  <= '0;
      y_q  <= '0;
    end else begin
      x1_q <= x1_d;
      m_q  <= m_d;
      x2_q <= x2_d;
      t_q  <= t_d;
      u_q  <= u_d;
      y_q  <= y_d;
    end
  end

  assign y = y_q;

`ifdef MONT_RANGE_CHK_EN
  always_comb begin
    e1_d = e1_q;
    e2_d = e2_q;
    e3_d = e3_q;
    e4_d = e4_q;
    if (en.s1) e1_d = (x >= X_LIMIT);
    if (en.s2) e2_d = e1_q;
    if (en.s3) e3_d = e2_q;
    if (en.s4) e4_d = e3_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e1_q <= 1'b0;
      e2_q <= 1'b0;
      e3_q <= 1'b0;
      e4_q <= 1'b0;
    end else begin
      e1_q <= e1_d;
      e2_q <= e2_d;
      e3_q <= e3_d;
      e4_q <= e4_d;
    end
  end

  assign err = e4_q;
`endif

endmodule

// File: rtl/montgomery_reduce_pipe.sv
// Multi-lane Montgomery reduction pipeline: shared valid/ready handshake with
// per-stage bubble collapsing. Define MONT_RANGE_CHK_EN to get out_err.
module montgomery_reduce_pipe
  import mont_pkg::*;
#(
  parameter int unsigned     NW      = KYBER_NW,
  parameter longint unsigned N       = KYBER_N,
  parameter int unsigned     R       = KYBER_R,
  parameter longint unsigned N_PRIME = KYBER_N_PRIME,
  parameter int unsigned     LANES   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*xw(NW, R)-1:0]   in_x,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*NW-1:0]          out_y
`ifdef MONT_RANGE_CHK_EN
  ,
  output logic [LANES-1:0]             out_err
`endif
);

  localparam int unsigned XW = xw(NW, R);

  logic v1_q, v1_d;
  logic v2_q, v2_d;
  logic v3_q, v3_d;
  logic v4_q, v4_d;
  logic adv1, adv2, adv3, adv4;
  logic accept;
  stage_en_t en;

  // A stage moves when it is empty or its successor moves, so bubbles collapse
  always_comb begin
    adv4   = !v4_q || out_ready;
    adv3   = !v3_q || adv4;
    adv2   = !v2_q || adv3;
    adv1   = !v1_q || adv2;
    accept = in_valid && adv1;

    v1_d = adv1 ? accept : v1_q;
    v2_d = adv2 ? v1_q   : v2_q;
    v3_d = adv3 ? v2_q   : v3_q;
    v4_d = adv4 ? v3_q   : v4_q;

    en.s1 = accept;
    en.s2 = adv2 && v1_q;
    en.s3 = adv3 && v2_q;
    en.s4 = adv4 && v3_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      v4_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      v4_q <= v4_d;
    end
  end

  assign in_ready  = adv1;
  assign out_valid = v4_q;

  for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
    mont_lane #(
      .NW      (NW),
      .N       (N),
      .R       (R),
      .N_PRIME (N_PRIME),
      .XW      (XW)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .x   (in_x[i*XW +: XW]),
      .y   (out_y[i*NW +: NW])
`ifdef MONT_RANGE_CHK_EN
      ,
      .err (out_err[i])
`endif
    );
  end

endmodule

// File: tb/tb_montgomery_reduce_pipe.sv
// Directed bench: Kyber 2-lane instance and Dilithium (R=23) 4-lane instance,
// checked against an independent X * (2^-1)^R mod N model.
module tb_montgomery_reduce_pipe;
  import mont_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Kyber instance, two lanes
  logic          k_rst, k_in_valid, k_in_ready, k_out_valid, k_out_ready;
  logic [47:0]   k_in_x;
  logic [23:0]   k_out_y;
  // Dilithium instance, four lanes, R = 23
  logic          d_rst, d_in_valid, d_in_ready, d_out_valid, d_out_ready;
  logic [183:0]  d_in_x;
  logic [91:0]   d_out_y;
`ifdef MONT_RANGE_CHK_EN
  logic [1:0]    k_out_err;
  logic [3:0]    d_out_err;
`endif

  montgomery_reduce_pipe #(.LANES(2)) dut_k (
    .clk(clk), .rst(k_rst), .in_valid(k_in_valid), .in_ready(k_in_ready),
    .in_x(k_in_x), .out_valid(k_out_valid), .out_ready(k_out_ready), .out_y(k_out_y)
`ifdef MONT_RANGE_CHK_EN
    , .out_err(k_out_err)
`endif
  );

  montgomery_reduce_pipe #(.NW(DIL_NW), .N(DIL_N), .R(DIL_R23), .N_PRIME(DIL_N_PRIME_R23),
                           .LANES(4)) dut_d (
    .clk(clk), .rst(d_rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_x(d_in_x), .out_valid(d_out_valid), .out_ready(d_out_ready), .out_y(d_out_y)
`ifdef MONT_RANGE_CHK_EN
    , .out_err(d_out_err)
`endif
  );

  int total = 0;
  int bad   = 0;
  int krx   = 0;
  int drx   = 0;
  logic [23:0] kq[$];
  logic [91:0] dq[$];

  // 2^-1 mod N is (N+1)/2; raise it to R and scale X mod N. Out-of-range gives 0.
  function automatic longint unsigned model(input longint unsigned x,
                                            input longint unsigned n, input int unsigned r);
    longint unsigned half, rinv;
    if (x >= (n << r)) return 0;
    half = (n + 1) / 2;
    rinv = 1;
    for (int i = 0; i < int'(r); i++) rinv = (rinv * half) % n;
    return ((x % n) * rinv) % n;
  endfunction

  function automatic logic [23:0] k_expect(input logic [47:0] x);
    return {12'(model(64'(x[47:24]), KYBER_N, KYBER_R)),
            12'(model(64'(x[23:0]),  KYBER_N, KYBER_R))};
  endfunction

  function automatic logic [91:0] d_expect(input logic [183:0] x);
    logic [91:0] e;
    e = '0;
    for (int l = 0; l < 4; l++) e[l*23 +: 23] = 23'(model(64'(x[l*46 +: 46]), DIL_N, DIL_R23));
    return e;
  endfunction

  function automatic logic [45:0] d_rand_lane();
    longint unsigned v;
    v = {$urandom, $urandom};
    return 46'(v % (DIL_N << DIL_R23));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic kstep(input bit iv, input logic [47:0] x, input bit ordy, output bit acc);
    logic [23:0] e;
    @(negedge clk);
    k_in_valid = iv; k_in_x = x; k_out_ready = ordy;
    #1;
    acc = iv && k_in_ready;
    if (k_out_valid && ordy) begin
      if (kq.size() == 0) begin
        total++; bad++;
        $error("FAIL k_extra_beat: observed=%0d expected=none", k_out_y);
      end else begin
        e = kq.pop_front();
        chk("k_y", k_out_y, e);
        krx++;
      end
    end
    if (acc) kq.push_back(k_expect(x));
  endtask

  task automatic dstep(input bit iv, input logic [183:0] x, input bit ordy, output bit acc);
    logic [91:0] e;
    @(negedge clk);
    d_in_valid = iv; d_in_x = x; d_out_ready = ordy;
    #1;
    acc = iv && d_in_ready;
    if (d_out_valid && ordy) begin
      if (dq.size() == 0) begin
        total++; bad++;
        $error("FAIL d_extra_beat: observed=%0h expected=none", d_out_y);
      end else begin
        e = dq.pop_front();
        for (int l = 0; l < 4; l++) chk("d_lane_y", d_out_y[l*23 +: 23], e[l*23 +: 23]);
        drx++;
      end
    end
    if (acc) dq.push_back(d_expect(x));
  endtask

  // one beat on an idle Kyber pipe; lane0 must give y0 exactly 4 cycles later
  task automatic k_single(input logic [23:0] x0, input logic [11:0] y0);
    bit acc;
    kstep(1'b1, {x0 >> 1, x0}, 1'b1, acc);
    chk("k_single_acc", acc, 1);
    for (int c = 1; c <= 4; c++) begin
      kstep(1'b0, '0, 1'b1, acc);
      chk("k_lat_valid", k_out_valid, c == 4);
    end
    chk("k_single_y0", k_out_y[11:0], y0);
  endtask

  logic [47:0] xs [8];
  int sent, rx0;
  bit acc;

  initial begin
    k_rst = 1'b1; k_in_valid = 1'b0; k_in_x = '0; k_out_ready = 1'b0;
    d_rst = 1'b1; d_in_valid = 1'b0; d_in_x = '0; d_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    k_rst = 1'b0; d_rst = 1'b0;
    #1;
    chk("k_rst_out_valid", k_out_valid, 0);
    chk("k_rst_in_ready", k_in_ready, 1);
    chk("k_rst_out_y", k_out_y, 0);
    chk("d_rst_out_valid", d_out_valid, 0);
    chk("d_rst_in_ready", d_in_ready, 1);
    chk("d_rst_out_y", d_out_y, 0);
`ifdef MONT_RANGE_CHK_EN
    chk("k_rst_out_err", k_out_err, 0);
`endif

    // hand-computed Kyber vectors
    k_single(24'd0,        12'd0);
    k_single(24'd4096,     12'd1);
    k_single(24'd20480,    12'd5);
    k_single(24'd3329,     12'd0);
    k_single(24'd13631488, 12'd3328);
    kstep(1'b0, '0, 1'b1, acc);

    // full-rate stream
    rx0 = krx;
    for (int c = 0; c < 1004; c++) begin
      kstep(c < 1000, {24'($urandom_range(0, 13635583)), 24'($urandom_range(0, 13635583))},
            1'b1, acc);
      if (c < 1000) chk("k_stream_ready", k_in_ready, 1);
      if (c >= 4) chk("k_stream_valid", k_out_valid, 1);
    end
    chk("k_stream_count", krx - rx0, 1000);

    // stall with consumer blocked, then release
    for (int i = 0; i < 8; i++)
      xs[i] = {24'($urandom_range(0, 13635583)), 24'($urandom_range(0, 13635583))};
    sent = 0;
    rx0  = krx;
    for (int c = 0; c < 10; c++) begin
      kstep(sent < 8, xs[sent < 8 ? sent : 0], 1'b0, acc);
      if (acc) sent++;
      if (k_out_valid) chk("k_stall_y", k_out_y, kq[0]);
    end
    chk("k_stall_accepted", sent, 4);
    chk("k_stall_in_ready", k_in_ready, 0);
    chk("k_stall_out_valid", k_out_valid, 1);
    for (int c = 0; c < 40 && (krx - rx0) < 8; c++) begin
      kstep(sent < 8, xs[sent < 8 ? sent : 0], 1'b1, acc);
      if (acc) sent++;
    end
    chk("k_stall_delivered", krx - rx0, 8);
    chk("k_stall_q_empty", kq.size(), 0);

    // reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      kstep(1'b1, {24'd4096, 24'(20480 + i)}, 1'b1, acc);
      chk("k_pre_rst_acc", acc, 1);
    end
    @(negedge clk);
    k_rst = 1'b1; k_in_valid = 1'b0;
    @(negedge clk);
    k_rst = 1'b0;
    #1;
    chk("k_midrst_out_valid", k_out_valid, 0);
    chk("k_midrst_in_ready", k_in_ready, 1);
    kq.delete();
    for (int c = 0; c < 8; c++) begin
      kstep(1'b0, '0, 1'b1, acc);
      chk("k_midrst_no_beat", k_out_valid, 0);
    end

`ifdef MONT_RANGE_CHK_EN
    kstep(1'b1, {24'd4096, 24'd13635584}, 1'b1, acc);
    for (int c = 1; c <= 4; c++) kstep(1'b0, '0, 1'b1, acc);
    chk("k_err_valid", k_out_valid, 1);
    chk("k_err_flags", k_out_err, 2'b01);
    chk("k_err_y", k_out_y, {12'd1, 12'd0});
    kstep(1'b0, '0, 1'b1, acc);
`endif

    // Dilithium: boundary beat, then random valid/ready toggling
    rx0  = drx;
    sent = 0;
    dstep(1'b1, {46'(64'd1 << 23), 46'(DIL_N), 46'((DIL_N << 23) - 1), 46'd0}, 1'b1, acc);
    if (acc) sent++;
    for (int c = 0; c < 4000 && (sent < 301 || (drx - rx0) < 301); c++) begin
      dstep((sent < 301) && ($urandom_range(0, 1) == 1),
            {d_rand_lane(), d_rand_lane(), d_rand_lane(), d_rand_lane()},
            $urandom_range(0, 1) == 1, acc);
      if (acc) sent++;
    end
    chk("d_count", drx - rx0, 301);
    chk("d_q_empty", dq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
